// File: rtl/pwm_capture_pkg.sv
// Shared widths, constants, FSM encoding and small helpers for the PWM capture block.
package pwm_capture_pkg;

  localparam int CNT_W  = 16;
  localparam int DIV_W  = 6;
  localparam int NUM_W  = 20;
  localparam int DUTY_W = 4;

  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = 16'hFFFF;
  localparam int                DUTY_SCALE  = 10;
  localparam logic [DUTY_W-1:0] DUTY_MAX    = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Divider numerator: high time scaled so the quotient lands directly in tenths.
  function automatic logic [NUM_W-1:0] scale_high(input logic [CNT_W-1:0] h);
    return NUM_W'(h) * NUM_W'(DUTY_SCALE);
  endfunction

  // The quotient can only exceed 10 if high > period, which a clean input never
  // produces; clamp anyway so the 4-bit output stays in range.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [NUM_W-1:0] q);
    if (q > NUM_W'(DUTY_MAX)) return DUTY_MAX;
    return q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clk. Loads on start, raises
// done for one clk after the last bit; abort drops any division in progress.
module seq_divider
  import pwm_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [CNT_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  logic [NUM_W-1:0] r_num;
  logic [CNT_W-1:0] r_den;
  logic [CNT_W-1:0] r_rem;
  logic [4:0]       r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W:0]   w_trial;
  logic [CNT_W:0]   w_diff;
  logic             w_qbit;

  // Remainder stays below den, so trial < 2*den and the borrow bit alone decides.
  assign w_trial = {r_rem, r_num[NUM_W-1]};
  assign w_diff  = w_trial - {1'b0, r_den};
  assign w_qbit  = ~w_diff[CNT_W];

  // Shift-subtract iteration; quotient bits shift into the numerator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (start) begin
      r_num  <= num;
      r_den  <= den;
      r_rem  <= '0;
      r_cnt  <= 5'(NUM_W);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_num <= {r_num[NUM_W-2:0], w_qbit};
        r_rem <= w_qbit ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_num;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in
// prescaled ticks and reports duty in tenths.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for the first rising edge, counters not meaningful
//   MEAS    | counting the current period, divider idle
//   DIV     | counting the current period while the divider works on the last
module pwm_capture
  import pwm_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  input  logic [DIV_W-1:0]  divisor,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              timeout,
  output logic              overrun
);

  logic             r_sync1;
  logic             r_sync2;
  logic [DIV_W-1:0] r_presc;
  logic [DIV_W-1:0] r_div_lat;
  logic             r_sample;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  state_t           r_state;

  state_t           w_next;
  logic             w_tick;
  logic             w_rise;
  logic [CNT_W-1:0] w_period_inc;
  logic [CNT_W-1:0] w_high_inc;
  logic             w_tmo_hit;
  logic             w_restart;
  logic             w_inc;
  logic             w_latch;
  logic             w_start;
  logic             w_ovr_set;
  logic             w_tmo;
  logic             w_abort;
  logic             w_duty_upd;
  logic             w_div_busy;
  logic             w_div_done;
  logic             w_div_active;
  logic [NUM_W-1:0] w_num;
  logic [NUM_W-1:0] w_quotient;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  // Prescaler; divisor is re-latched on each wrap so a change never shortens a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_div_lat <= '0;
    end else if (!ena || w_tick) begin
      r_presc   <= '0;
      r_div_lat <= divisor;
    end else begin
      r_presc   <= r_presc + 6'd1;
    end
  end

  assign w_tick = ena && (r_presc == r_div_lat);
  assign w_rise = w_tick && r_sync2 && !r_sample;

  // Previous tick's sample, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sample <= 1'b0;
    else if (w_tick) r_sample <= r_sync2;
  end

  assign w_period_inc = r_period + 16'd1;
  assign w_high_inc   = r_high + {{(CNT_W-1){1'b0}}, r_sync2};
  assign w_tmo_hit    = (w_period_inc == TIMEOUT_VAL);
  assign w_div_active = w_div_busy || w_div_done;
  assign w_num        = scale_high(r_high);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_next     = r_state;
    w_restart  = 1'b0;
    w_inc      = 1'b0;
    w_latch    = 1'b0;
    w_start    = 1'b0;
    w_ovr_set  = 1'b0;
    w_tmo      = 1'b0;
    w_abort    = 1'b0;
    w_duty_upd = 1'b0;
    if (!ena) begin
      w_next  = ST_IDLE;
      w_abort = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_restart = 1'b1;
            w_next    = ST_MEAS;
          end
        end
        ST_MEAS, ST_DIV: begin
          if (w_rise) begin
            w_restart = 1'b1;
            if (r_state == ST_MEAS && !w_div_active) begin
              w_latch = 1'b1;
              w_start = 1'b1;
              w_next  = ST_DIV;
            end else begin
              w_ovr_set = 1'b1;
            end
          end else if (w_tick) begin
            if (w_tmo_hit) begin
              w_tmo   = 1'b1;
              w_abort = 1'b1;
              w_next  = ST_IDLE;
            end else begin
              w_inc = 1'b1;
            end
          end
          // The done cycle still counts as busy for an edge arriving with it.
          if (r_state == ST_DIV && w_div_done && !w_tmo) begin
            w_duty_upd = 1'b1;
            w_next     = ST_MEAS;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Period and high-time counters; the rising-edge sample opens the new period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_high   <= '0;
    end else if (w_restart) begin
      r_period <= 16'd1;
      r_high   <= 16'd1;
    end else if (w_inc) begin
      r_period <= w_period_inc;
      r_high   <= w_high_inc;
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .abort    (w_abort),
    .num      (w_num),
    .den      (r_period),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quotient)
  );

  // Result registers; a timeout overrides any other update in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (w_tmo) begin
        timeout    <= 1'b1;
        period_cnt <= TIMEOUT_VAL;
        high_cnt   <= r_sync2 ? TIMEOUT_VAL : '0;
        duty       <= r_sync2 ? DUTY_MAX : '0;
        duty_valid <= 1'b1;
      end else begin
        if (w_latch) begin
          high_cnt   <= r_high;
          period_cnt <= r_period;
          timeout    <= 1'b0;
        end
        if (w_duty_upd) begin
          duty       <= clamp_duty(w_quotient);
          duty_valid <= 1'b1;
        end
      end
      if (w_ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: vector table of steady PWM patterns plus
// hand-written sequences for overrun, reset, enable and timeout corners.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        pwm_in;
  logic        pwm_in_b;
  logic [5:0]  divisor = 6'd0;
  logic [15:0] high_cnt, period_cnt, high_cnt_b, period_cnt_b;
  logic [3:0]  duty, duty_b;
  logic        duty_valid, timeout, overrun;
  logic        duty_valid_b, timeout_b, overrun_b;

  int n_vec = 0;
  int n_err = 0;

  bit gen_on = 1'b0;
  bit gen_level = 1'b0;
  bit gen_b_sel = 1'b0;
  bit gen_b_level = 1'b0;
  int gen_hi = 1;
  int gen_lo = 1;
  int gen_pos = 0;

  typedef struct {
    int dv;
    int hi;
    int lo;
    int e_high;
    int e_per;
    int e_duty;
    int e_ovr;
  } vec_t;

  vec_t vecs[10];
  bit   ok;
  int   vcnt;
  int   lat;

  pwm_capture u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .divisor    (divisor),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty       (duty),
    .duty_valid (duty_valid),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  // Second instance lets both timeout flavours run in one 65535-tick window.
  pwm_capture u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pwm_in     (pwm_in_b),
    .divisor    (divisor),
    .high_cnt   (high_cnt_b),
    .period_cnt (period_cnt_b),
    .duty       (duty_b),
    .duty_valid (duty_valid_b),
    .timeout    (timeout_b),
    .overrun    (overrun_b)
  );

  always #5 clk = ~clk;

  // PWM pattern generator, updates 2 time units after each rising clk edge.
  initial begin
    pwm_in   = 1'b0;
    pwm_in_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_on) begin
        pwm_in  = (gen_pos < gen_hi);
        gen_pos = (gen_pos + 1 >= gen_hi + gen_lo) ? 0 : gen_pos + 1;
      end else begin
        pwm_in  = gen_level;
        gen_pos = 0;
      end
      pwm_in_b = gen_b_sel ? gen_b_level : pwm_in;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, input string name, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (duty_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no duty_valid within %0d clk, expected a pulse", name, budget);
    end
  endtask

  task automatic do_reset(input logic [5:0] dv);
    gen_on    = 1'b0;
    gen_level = 1'b0;
    gen_b_sel = 1'b0;
    rst_n     = 1'b0;
    divisor   = dv;
    ena       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{0,   5,   5,   5,  10, 5, 1};
    vecs[1] = '{3,  12,  28,   3,  10, 3, 0};
    vecs[2] = '{0,   3,   7,   3,  10, 3, 1};
    vecs[3] = '{0,   1,   9,   1,  10, 1, 1};
    vecs[4] = '{0,  10,   1,  10,  11, 9, 1};
    vecs[5] = '{1,   6,   2,   3,   4, 7, 1};
    vecs[6] = '{0,  30,  10,  30,  40, 7, 0};
    vecs[7] = '{2,   9,  21,   3,  10, 3, 0};
    vecs[8] = '{0, 100, 100, 100, 200, 5, 0};
    vecs[9] = '{0,  39,   1,  39,  40, 9, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_high",    int'(high_cnt),   0);
    chk("rst_period",  int'(period_cnt), 0);
    chk("rst_duty",    int'(duty),       0);
    chk("rst_valid",   int'(duty_valid), 0);
    chk("rst_timeout", int'(timeout),    0);
    chk("rst_overrun", int'(overrun),    0);

    // Steady patterns: check the second reported result of each
    for (int i = 0; i < 10; i++) begin
      do_reset(6'(vecs[i].dv));
      gen_hi = vecs[i].hi;
      gen_lo = vecs[i].lo;
      gen_on = 1'b1;
      wait_valid(2000, $sformatf("v%0d_first", i), ok);
      if (ok) wait_valid(2000, $sformatf("v%0d_second", i), ok);
      if (ok) begin
        chk($sformatf("v%0d_high", i),    int'(high_cnt),   vecs[i].e_high);
        chk($sformatf("v%0d_period", i),  int'(period_cnt), vecs[i].e_per);
        chk($sformatf("v%0d_duty", i),    int'(duty),       vecs[i].e_duty);
        chk($sformatf("v%0d_overrun", i), int'(overrun),    vecs[i].e_ovr);
      end
    end

    // Overrun: 4-clk period is shorter than a divide
    do_reset(6'd0);
    @(negedge clk);
    chk("ovr_after_reset", int'(overrun), 0);
    gen_hi = 2;
    gen_lo = 2;
    gen_on = 1'b1;
    wait_valid(200, "ovr_first", ok);
    if (ok) begin
      chk("ovr_duty",    int'(duty),       5);
      chk("ovr_high",    int'(high_cnt),   2);
      chk("ovr_period",  int'(period_cnt), 4);
      chk("ovr_overrun", int'(overrun),    1);
    end

    // Reset pulsed while the divider is running
    do_reset(6'd0);
    gen_hi = 20;
    gen_lo = 20;
    gen_on = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (period_cnt != 16'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mdrst_latch_seen", int'(ok), 1);
    repeat (5) @(negedge clk);
    rst_n  = 1'b0;
    gen_on = 1'b0;
    vcnt   = 0;
    repeat (4) begin
      @(negedge clk);
      if (duty_valid) vcnt++;
    end
    chk("mdrst_high",    int'(high_cnt),   0);
    chk("mdrst_period",  int'(period_cnt), 0);
    chk("mdrst_duty",    int'(duty),       0);
    chk("mdrst_timeout", int'(timeout),    0);
    chk("mdrst_overrun", int'(overrun),    0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (duty_valid) vcnt++;
    end
    chk("mdrst_no_valid", vcnt, 0);
    gen_on = 1'b1;
    wait_valid(300, "mdrst_result", ok);
    if (ok) begin
      chk("mdrst_res_high",   int'(high_cnt),   20);
      chk("mdrst_res_period", int'(period_cnt), 40);
      chk("mdrst_res_duty",   int'(duty),       5);
    end

    // Enable dropped for 50 clk mid-period
    do_reset(6'd0);
    gen_hi = 20;
    gen_lo = 20;
    gen_on = 1'b1;
    wait_valid(300, "ena_first", ok);
    ena  = 1'b0;
    vcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (duty_valid) vcnt++;
    end
    chk("ena_low_no_valid", vcnt, 0);
    chk("ena_hold_high",   int'(high_cnt),   20);
    chk("ena_hold_period", int'(period_cnt), 40);
    chk("ena_hold_duty",   int'(duty),       5);
    ena = 1'b1;
    lat = 0;
    wait_valid(400, "ena_resume", ok);
    if (ok) begin
      chk("ena_res_high",   int'(high_cnt),   20);
      chk("ena_res_period", int'(period_cnt), 40);
      chk("ena_res_duty",   int'(duty),       5);
    end

    // Re-run the resume and measure latency: two rising edges plus the divide
    ena = 1'b0;
    repeat (50) @(negedge clk);
    ena = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (duty_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ena_latency_two_edges", int'(ok && lat >= 61), 1);

    // Timeout: instance A held high, instance B pulsed then held low
    do_reset(6'd0);
    gen_level   = 1'b1;
    gen_b_sel   = 1'b1;
    gen_b_level = 1'b1;
    repeat (3) @(posedge clk);
    gen_b_level = 1'b0;
    vcnt = 0;
    repeat (65000) begin
      @(negedge clk);
      if (duty_valid) vcnt++;
    end
    chk("tmo_not_early", int'(timeout), 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (duty_valid) vcnt++;
      if (timeout) break;
    end
    chk("tmo_flag",   int'(timeout),    1);
    chk("tmo_high",   int'(high_cnt),   65535);
    chk("tmo_period", int'(period_cnt), 65535);
    chk("tmo_duty",   int'(duty),       10);
    repeat (20) begin
      @(negedge clk);
      if (duty_valid) vcnt++;
    end
    chk("tmo_valid_once", vcnt, 1);
    chk("tmo_held",       int'(timeout),      1);
    chk("tmo0_flag",      int'(timeout_b),    1);
    chk("tmo0_high",      int'(high_cnt_b),   0);
    chk("tmo0_period",    int'(period_cnt_b), 65535);
    chk("tmo0_duty",      int'(duty_b),       0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
